fetch_issue_queue: RTL and testbench

- Parametrised instruction queue that replaces the single-entry fetch-to-decode pipeline register.
- Decouples the fetch stage from decode so instruction-fetch latency is absorbed, and presents up to ISSUE oldest entries per cycle to decode (ISSUE=2 prepares dual issue).
- Supports full flush (exception, eret, mispredict) and a delay-slot-preserving flush that keeps only the oldest entry.

---
 rtl/fetch_issue_queue_pkg.sv | 36 +++
 rtl/fetch_issue_queue.sv | 127 ++++++++++++
 tb/tb_fetch_issue_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_issue_queue_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package fetch_issue_queue_pkg;

    // Default geometry: eight entries, dual-lane push and pop.
    localparam int FIQ_DEPTH = 8;
    localparam int FIQ_ISSUE = 2;

    // Basic queue entry. pc sits in the upper half so the payload reads {pc, instr}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fiq_entry_t;

    localparam int FIQ_ENTRY_W = $bits(fiq_entry_t);

    // TLB fault class raised during instruction fetch.
    typedef enum logic [1:0] {
        TLB_NONE    = 2'd0,
        TLB_REFILL  = 2'd1,
        TLB_INVALID = 2'd2,
        TLB_MOD     = 2'd3
    } tlb_exc_t;

    // Entry carrying fetch exception flags; instantiate the queue with
    // ENTRY_W = FIQ_EXC_ENTRY_W to use it.
    typedef struct packed {
        fiq_entry_t base;
        logic       addr_err_if;
        tlb_exc_t   tlb_exc;
    } fiq_exc_entry_t;

    localparam int FIQ_EXC_ENTRY_W = $bits(fiq_exc_entry_t);

endpackage

// File: rtl/fetch_issue_queue.sv
// Circular instruction queue between fetch and decode, up to ISSUE lanes push/pop per cycle.
// Latency: a pushed entry appears on out_data the cycle after the push (no bypass).
// Backpressure: push_ready depends only on registered occupancy; pushes are dropped when it is low.
module fetch_issue_queue
    import fetch_issue_queue_pkg::*;
#(
    parameter int ENTRY_W = FIQ_ENTRY_W,
    parameter int DEPTH   = FIQ_DEPTH,
    parameter int ISSUE   = FIQ_ISSUE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(ISSUE+1)-1:0]   push_cnt,
    input  logic [ISSUE*ENTRY_W-1:0]     push_data,
    output logic                         push_ready,
    output logic [ISSUE-1:0]             out_valid,
    output logic [ISSUE*ENTRY_W-1:0]     out_data,
    input  logic [$clog2(ISSUE+1)-1:0]   pop_cnt,
    input  logic                         flush,
    input  logic                         flush_keep_head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(ISSUE+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE);

    // Pointer plus small offset, wrapping modulo DEPTH by truncation.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] off);
        return p + PW'(off);
    endfunction

    // Thermometer code: lane i is valid while occupancy exceeds i.
    function automatic logic [ISSUE-1:0] lane_valid(input logic [CW-1:0] cnt);
        logic [ISSUE-1:0] v;
        v = '0;
        for (int i = 0; i < ISSUE; i++) begin
            v[i] = (cnt > CW'(i));
        end
        return v;
    endfunction

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      push_n, pop_n;
    logic [ISSUE-1:0]   wr_lane;

    assign push_ready = ((DEPTH_C - count_q) >= ISSUE_C);
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign out_valid  = lane_valid(count_q);

    // Present the oldest ISSUE entries, head first, straight from storage.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < ISSUE; i++) begin
            out_data[i*ENTRY_W +: ENTRY_W] = mem_q[ptr_add(head_q, CW'(i))];
        end
    end

    // Next-state pointers and occupancy; flush variants win over push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_lane = '0;
        push_n  = push_ready ? CW'(push_cnt) : '0;
        // Over-popping is illegal; clamping keeps the pointers coherent anyway.
        pop_n   = (CW'(pop_cnt) > count_q) ? count_q : CW'(pop_cnt);
        if (flush || (flush_keep_head && count_q == '0)) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (flush_keep_head) begin
            // Keep only the delay-slot entry sitting at head.
            tail_d  = ptr_add(head_q, CW'(1));
            count_d = CW'(1);
        end else begin
            head_d  = ptr_add(head_q, pop_n);
            tail_d  = ptr_add(tail_q, push_n);
            count_d = count_q + push_n - pop_n;
            for (int i = 0; i < ISSUE; i++) begin
                wr_lane[i] = (CW'(i) < push_n);
            end
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE; i++) begin
            if (!rst && wr_lane[i]) begin
                mem_q[ptr_add(tail_q, CW'(i))] <= push_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Decode never consumes more than is present; fetch never offers more than ISSUE lanes.
    always_ff @(posedge clk) begin
        if (!rst && !flush && !flush_keep_head) begin
            assert (CW'(pop_cnt) <= count_q);
        end
        if (!rst) begin
            assert (push_cnt <= NW'(ISSUE));
        end
    end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Self-checking bench for fetch_issue_queue (DEPTH=8, ISSUE=2): vector table,
// hand sequences for wrap and full, then randomized traffic against a queue model.
module tb_fetch_issue_queue;

    localparam int EW = 64;
    localparam int DP = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     push_cnt = '0;
    logic [2*EW-1:0] push_data = '0;
    logic           push_ready;
    logic [1:0]     out_valid;
    logic [2*EW-1:0] out_data;
    logic [1:0]     pop_cnt = '0;
    logic           flush = 1'b0;
    logic           flush_keep_head = 1'b0;
    logic [3:0]     count;
    logic           empty;
    logic           full;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    bit          model_ok = 0;

    always #5 clk = ~clk;

    fetch_issue_queue #(.ENTRY_W(EW), .DEPTH(DP), .ISSUE(2)) dut (
        .clk(clk), .rst(rst),
        .push_cnt(push_cnt), .push_data(push_data), .push_ready(push_ready),
        .out_valid(out_valid), .out_data(out_data),
        .pop_cnt(pop_cnt), .flush(flush), .flush_keep_head(flush_keep_head),
        .count(count), .empty(empty), .full(full)
    );

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'h1357_9BDF};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Compare every visible output against the abstract FIFO model.
    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("m_count", 64'(count), 64'(sz));
        chk("m_empty", 64'(empty), 64'(sz == 0));
        chk("m_full", 64'(full), 64'(sz == DP));
        chk("m_ready", 64'(push_ready), 64'((DP - sz) >= 2));
        chk("m_valid", 64'(out_valid), 64'({sz > 1, sz > 0}));
        if (sz > 0) chk("m_lane0", out_data[EW-1:0], mq[0]);
        if (sz > 1) chk("m_lane1", out_data[2*EW-1:EW], mq[1]);
    endtask

    // One clock: check current state, drive inputs, advance the model with the edge.
    task automatic step(input logic r, input logic f, input logic k, input int pn,
                        input logic [31:0] pa, input logic [31:0] pb, input int pp);
        bit          rdy;
        logic [63:0] e;
        if (model_ok) check_model();
        rst = r; flush = f; flush_keep_head = k;
        push_cnt = 2'(pn); pop_cnt = 2'(pp);
        push_data = {mk(pb), mk(pa)};
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else if (k) begin
            if (mq.size() > 0) begin
                e = mq[0];
                mq.delete();
                mq.push_back(e);
            end
        end else begin
            rdy = ((DP - mq.size()) >= 2);
            for (int i = 0; i < pp; i++) if (mq.size() > 0) void'(mq.pop_front());
            if (rdy) begin
                if (pn > 0) mq.push_back(mk(pa));
                if (pn > 1) mq.push_back(mk(pb));
            end
        end
        if (r) model_ok = 1;
        #1;
    endtask

    typedef struct {
        logic        r, f, k;
        int          pn;
        logic [31:0] pa, pb;
        int          pp;
        int          ec;
        logic [1:0]  ev;
        logic        er;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic f, input logic k, input int pn,
                               input logic [31:0] pa, input int pp, input int ec,
                               input logic [1:0] ev, input logic er, input logic [31:0] epc);
        vec_t x;
        x.r = r; x.f = f; x.k = k; x.pn = pn; x.pa = pa; x.pb = pa + 32'd4; x.pp = pp;
        x.ec = ec; x.ev = ev; x.er = er; x.epc = epc;
        return x;
    endfunction

    vec_t tbl[21];

    initial begin
        logic [31:0] nxt, hd, ra, rb;
        int          sz, pp, pn;
        logic        rr, rf, rk;

        //          r  f  k  pn pa            pp cnt valid rdy lane0-pc
        tbl[0]  = v(1, 0, 0, 0, 32'h0,        0, 0, 2'b00, 1, 32'h0);
        tbl[1]  = v(0, 0, 0, 0, 32'h0,        0, 0, 2'b00, 1, 32'h0);
        tbl[2]  = v(0, 0, 0, 2, 32'hBFC00000, 0, 2, 2'b11, 1, 32'hBFC00000);
        tbl[3]  = v(0, 0, 0, 2, 32'hBFC00008, 0, 4, 2'b11, 1, 32'hBFC00000);
        tbl[4]  = v(0, 0, 0, 2, 32'hBFC00010, 0, 6, 2'b11, 1, 32'hBFC00000);
        tbl[5]  = v(0, 0, 0, 1, 32'hBFC00018, 0, 7, 2'b11, 0, 32'hBFC00000);
        tbl[6]  = v(0, 0, 0, 2, 32'hBFC00020, 0, 7, 2'b11, 0, 32'hBFC00000);
        tbl[7]  = v(0, 0, 0, 2, 32'hBFC00020, 2, 5, 2'b11, 1, 32'hBFC00008);
        tbl[8]  = v(0, 0, 0, 0, 32'h0,        2, 3, 2'b11, 1, 32'hBFC00010);
        tbl[9]  = v(1, 0, 0, 0, 32'h0,        0, 0, 2'b00, 1, 32'h0);
        tbl[10] = v(0, 0, 0, 2, 32'h80000010, 0, 2, 2'b11, 1, 32'h80000010);
        tbl[11] = v(0, 0, 0, 2, 32'h80000018, 0, 4, 2'b11, 1, 32'h80000010);
        tbl[12] = v(0, 0, 0, 1, 32'h80000020, 0, 5, 2'b11, 1, 32'h80000010);
        tbl[13] = v(0, 0, 1, 2, 32'h80000024, 1, 1, 2'b01, 1, 32'h80000010);
        tbl[14] = v(0, 0, 0, 0, 32'h0,        1, 0, 2'b00, 1, 32'h0);
        tbl[15] = v(0, 0, 0, 2, 32'h90000000, 0, 2, 2'b11, 1, 32'h90000000);
        tbl[16] = v(1, 1, 0, 2, 32'h90000008, 0, 0, 2'b00, 1, 32'h0);
        tbl[17] = v(0, 0, 0, 2, 32'hA0000000, 0, 2, 2'b11, 1, 32'hA0000000);
        tbl[18] = v(0, 0, 0, 2, 32'hA0000008, 0, 4, 2'b11, 1, 32'hA0000000);
        tbl[19] = v(0, 1, 0, 0, 32'h0,        2, 0, 2'b00, 1, 32'h0);
        tbl[20] = v(0, 0, 1, 2, 32'hA0000010, 0, 0, 2'b00, 1, 32'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].k, tbl[i].pn, tbl[i].pa, tbl[i].pb, tbl[i].pp);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].ec));
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d_ready", i), 64'(push_ready), 64'(tbl[i].er));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tbl[i].ec == 0));
            if (tbl[i].ev[0]) chk($sformatf("v%0d_pc0", i), 64'(out_data[63:32]), 64'(tbl[i].epc));
        end

        // Wrap-around: steady push-2/pop-2 must stream pcs strictly in order.
        step(0, 0, 0, 2, 32'hC0000000, 32'hC0000004, 0);
        hd = 32'hC0000000;
        nxt = 32'hC0000008;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrap%0d_pc0", i), 64'(out_data[63:32]), 64'(hd));
            chk($sformatf("wrap%0d_pc1", i), 64'(out_data[127:96]), 64'(hd + 32'd4));
            chk($sformatf("wrap%0d_count", i), 64'(count), 64'd2);
            step(0, 0, 0, 2, nxt, nxt + 32'd4, 2);
            hd = hd + 32'd8;
            nxt = nxt + 32'd8;
        end

        // Fill to capacity, then pop with a push that stale ready must block.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2, nxt, nxt + 32'd4, 0);
            nxt = nxt + 32'd8;
        end
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(push_ready), 64'd0);
        chk("full_count", 64'(count), 64'd8);
        step(0, 0, 0, 2, nxt, nxt + 32'd4, 2);
        chk("unfull_count", 64'(count), 64'd6);
        chk("unfull_pc0", 64'(out_data[63:32]), 64'(hd + 32'd8));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            sz = mq.size();
            rr = ($urandom_range(0, 199) == 0);
            rf = ($urandom_range(0, 31) == 0);
            rk = ($urandom_range(0, 31) == 0);
            pn = int'($urandom_range(0, 2));
            pp = int'($urandom_range(0, (sz < 2) ? sz : 2));
            ra = $urandom;
            rb = $urandom;
            step(rr, rf, rk, pn, ra, rb, pp);
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
